// File: rtl/ucie_pkg.sv
// Shared types and defaults for the UCIe protocol-stack WRR scheduler.
package ucie_pkg;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_GRANT
    } wrr_state_t;

    localparam int WRR_STARVE_LIMIT_DEF = 64;

endpackage

// File: rtl/ucie_stack_wrr_scheduler_if.sv
// Request/grant/credit bundle between the protocol stacks and the WRR scheduler.
interface ucie_stack_wrr_scheduler_if #(
    parameter int NUM_STACKS = 4,
    parameter int WEIGHT_W   = 4,
    parameter int CREDIT_W   = 8
);
    localparam int ID_W = $clog2(NUM_STACKS);

    logic [NUM_STACKS-1:0]               stack_enable;
    logic [NUM_STACKS-1:0]               stack_req;
    logic [NUM_STACKS-1:0][WEIGHT_W-1:0] stack_weight;
    logic [NUM_STACKS-1:0][CREDIT_W-1:0] credit_init;
    logic [NUM_STACKS-1:0]               credit_ret;
    logic                                tx_fire;
    logic                                grant_valid;
    logic [ID_W-1:0]                     grant_id;
    logic [NUM_STACKS-1:0]               grant_onehot;
    logic [NUM_STACKS-1:0][CREDIT_W-1:0] credit_level;
    logic [NUM_STACKS-1:0]               starved;
    logic                                err_spurious;

    modport master (
        output stack_enable, stack_req, stack_weight,
        output credit_init, credit_ret, tx_fire,
        input  grant_valid, grant_id, grant_onehot,
        input  credit_level, starved, err_spurious
    );

    modport slave (
        input  stack_enable, stack_req, stack_weight,
        input  credit_init, credit_ret, tx_fire,
        output grant_valid, grant_id, grant_onehot,
        output credit_level, starved, err_spurious
    );

endinterface

// File: rtl/ucie_rr_pick.sv
// Rotating-priority picker: first set req bit strictly after ptr, wrapping.
module ucie_rr_pick #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] idx,
    output logic            found
);

    logic [ID_W-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = ID_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ucie_stack_wrr_scheduler.sv
// Weighted round-robin, credit-aware owner selection for the shared D2D TX stream.
module ucie_stack_wrr_scheduler
    import ucie_pkg::*;
#(
    parameter int NUM_STACKS   = 4,
    parameter int WEIGHT_W     = 4,
    parameter int CREDIT_W     = 8,
    parameter int STARVE_LIMIT = WRR_STARVE_LIMIT_DEF
) (
    input logic clk,
    input logic rst_n,
    input logic cfg_reinit,
    ucie_stack_wrr_scheduler_if.slave bus
);

    localparam int ID_W   = $clog2(NUM_STACKS);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    wrr_state_t                          state_q, state_d;
    logic [ID_W-1:0]                     rr_ptr_q, rr_ptr_d;
    logic                                grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]                     grant_id_q, grant_id_d;
    logic [NUM_STACKS-1:0]               grant_onehot_q, grant_onehot_d;
    logic [WEIGHT_W-1:0]                 quantum_q, quantum_d;
    logic [NUM_STACKS-1:0][CREDIT_W-1:0] credit_q, credit_d;
    logic [NUM_STACKS-1:0][WAIT_W-1:0]   wait_q, wait_d;
    logic [NUM_STACKS-1:0]               starved_q, starved_d;
    logic                                err_q, err_d;

    logic [NUM_STACKS-1:0] eligible;
    logic [ID_W-1:0]       pick_idx;
    logic                  pick_found;
    logic [WEIGHT_W-1:0]   pick_weight;
    logic                  fire_g;
    logic                  release_g;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_STACKS; i++) begin
            eligible[i] = bus.stack_enable[i] && bus.stack_req[i]
                       && (credit_q[i] != '0);
        end
    end

    ucie_rr_pick #(.N(NUM_STACKS)) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign pick_weight = bus.stack_weight[pick_idx];
    assign fire_g      = (state_q == S_GRANT) && bus.tx_fire;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_valid_d  = grant_valid_q;
        grant_id_d     = grant_id_q;
        grant_onehot_d = grant_onehot_q;
        quantum_d      = quantum_q;
        release_g      = 1'b0;
        unique case (state_q)
            S_INIT: state_d = S_IDLE;
            S_IDLE: begin
                if (pick_found) begin
                    state_d        = S_GRANT;
                    grant_valid_d  = 1'b1;
                    grant_id_d     = pick_idx;
                    grant_onehot_d = NUM_STACKS'(1) << pick_idx;
                    quantum_d      = (pick_weight == '0) ? WEIGHT_W'(1)
                                                         : pick_weight;
                end
            end
            S_GRANT: begin
                if (bus.tx_fire) begin
                    quantum_d = quantum_q - WEIGHT_W'(1);
                    release_g = (quantum_q == WEIGHT_W'(1))
                             || (credit_q[grant_id_q] == CREDIT_W'(1));
                end else begin
                    release_g = !bus.stack_enable[grant_id_q]
                             || !bus.stack_req[grant_id_q];
                end
                if (release_g) begin
                    rr_ptr_d       = grant_id_q;
                    state_d        = S_IDLE;
                    grant_valid_d  = 1'b0;
                    grant_id_d     = '0;
                    grant_onehot_d = '0;
                end
            end
            default: state_d = S_INIT;
        endcase
        // Re-init drops the grant, but a same-cycle fire still spends its credit.
        if (cfg_reinit) begin
            state_d        = S_INIT;
            grant_valid_d  = 1'b0;
            grant_id_d     = '0;
            grant_onehot_d = '0;
        end
    end

    always_comb begin
        credit_d  = credit_q;
        wait_d    = wait_q;
        starved_d = '0;
        for (int i = 0; i < NUM_STACKS; i++) begin
            if (state_q == S_INIT) begin
                credit_d[i] = bus.credit_init[i];
            end else if (bus.credit_ret[i] && !(fire_g && grant_onehot_q[i])) begin
                if (credit_q[i] != '1) credit_d[i] = credit_q[i] + CREDIT_W'(1);
            end else if (!bus.credit_ret[i] && fire_g && grant_onehot_q[i]) begin
                if (credit_q[i] != '0) credit_d[i] = credit_q[i] - CREDIT_W'(1);
            end
            if (state_q == S_INIT || !eligible[i] || grant_onehot_d[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != '1) begin
                wait_d[i] = wait_q[i] + WAIT_W'(1);
            end
            starved_d[i] = (wait_d[i] >= WAIT_W'(STARVE_LIMIT));
        end
        err_d = (state_q == S_INIT) ? 1'b0
              : (err_q || (bus.tx_fire && !grant_valid_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_INIT;
            rr_ptr_q       <= ID_W'(NUM_STACKS - 1);
            grant_valid_q  <= 1'b0;
            grant_id_q     <= '0;
            grant_onehot_q <= '0;
            quantum_q      <= '0;
            credit_q       <= '0;
            wait_q         <= '0;
            starved_q      <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_valid_q  <= grant_valid_d;
            grant_id_q     <= grant_id_d;
            grant_onehot_q <= grant_onehot_d;
            quantum_q      <= quantum_d;
            credit_q       <= credit_d;
            wait_q         <= wait_d;
            starved_q      <= starved_d;
            err_q          <= err_d;
        end
    end

    assign bus.grant_valid  = grant_valid_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.grant_onehot = grant_onehot_q;
    assign bus.credit_level = credit_q;
    assign bus.starved      = starved_q;
    assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_ucie_stack_wrr_scheduler.sv
// Vector table plus scoreboarded corner-case sequences for the WRR scheduler.
module tb_ucie_stack_wrr_scheduler;

    typedef struct packed {
        logic            gv;
        logic [1:0]      gid;
        logic [3:0][7:0] cred;
        logic [3:0]      stv;
        logic            err;
    } exp_t;

    typedef struct {
        logic       rst_n;
        logic       reinit;
        logic [3:0] en;
        logic [3:0] req;
        logic [3:0] ret;
        logic       fire;
        exp_t       x;
    } vec_t;

    logic clk;
    logic rst_n;
    logic cfg_reinit;
    int   n_pass;
    int   n_total;
    exp_t sb[$];
    vec_t tbl[$];

    ucie_stack_wrr_scheduler_if #(
        .NUM_STACKS(4), .WEIGHT_W(4), .CREDIT_W(8)
    ) bus ();

    ucie_stack_wrr_scheduler #(
        .NUM_STACKS(4), .WEIGHT_W(4), .CREDIT_W(8), .STARVE_LIMIT(64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_reinit (cfg_reinit),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its end");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input int rn, input int ri, input int en,
                                input int req, input int ret, input int fire,
                                input int gv, input int gid,
                                input int c0, input int c1, input int c2,
                                input int c3, input int stv, input int err);
        vec_t v;
        v.rst_n     = 1'(rn);
        v.reinit    = 1'(ri);
        v.en        = 4'(en);
        v.req       = 4'(req);
        v.ret       = 4'(ret);
        v.fire      = 1'(fire);
        v.x.gv      = 1'(gv);
        v.x.gid     = 2'(gid);
        v.x.cred[0] = 8'(c0);
        v.x.cred[1] = 8'(c1);
        v.x.cred[2] = 8'(c2);
        v.x.cred[3] = 8'(c3);
        v.x.stv     = 4'(stv);
        v.x.err     = 1'(err);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, req);
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t       e;
        logic [3:0] oh;
        rst_n            = v.rst_n;
        cfg_reinit       = v.reinit;
        bus.stack_enable = v.en;
        bus.stack_req    = v.req;
        bus.credit_ret   = v.ret;
        bus.tx_fire      = v.fire;
        sb.push_back(v.x);
        @(posedge clk);
        #1;
        e  = sb.pop_front();
        oh = e.gv ? (4'b0001 << e.gid) : 4'b0000;
        chk({tag, ".grant_valid"}, 32'(bus.grant_valid), 32'(e.gv));
        if (e.gv) chk({tag, ".grant_id"}, 32'(bus.grant_id), 32'(e.gid));
        chk({tag, ".grant_onehot"}, 32'(bus.grant_onehot), 32'(oh));
        chk({tag, ".credit_level"}, bus.credit_level, e.cred);
        chk({tag, ".starved"}, 32'(bus.starved), 32'(e.stv));
        chk({tag, ".err_spurious"}, 32'(bus.err_spurious), 32'(e.err));
    endtask

    initial begin
        n_pass           = 0;
        n_total          = 0;
        rst_n            = 1'b0;
        cfg_reinit       = 1'b0;
        bus.stack_enable = '0;
        bus.stack_req    = '0;
        bus.credit_ret   = '0;
        bus.tx_fire      = 1'b0;
        bus.stack_weight = {4'd1, 4'd3, 4'd1, 4'd2};
        bus.credit_init  = {8'd8, 8'd8, 8'd8, 8'd8};

        apply(mk(0,0,0,0,0,0, 0,0, 0,0,0,0, 0,0), "reset");

        // rn ri en req ret fire | gv gid | c0 c1 c2 c3 | stv err
        tbl.push_back(mk(1,0,15,5,0,0, 0,0, 8,8,8,8, 0,0));
        tbl.push_back(mk(1,0,15,5,0,0, 1,0, 8,8,8,8, 0,0));
        tbl.push_back(mk(1,0,15,5,0,1, 1,0, 7,8,8,8, 0,0));
        tbl.push_back(mk(1,0,15,5,0,1, 0,0, 6,8,8,8, 0,0));
        tbl.push_back(mk(1,0,15,5,0,0, 1,2, 6,8,8,8, 0,0));
        tbl.push_back(mk(1,0,15,5,0,1, 1,2, 6,8,7,8, 0,0));
        tbl.push_back(mk(1,0,15,5,0,1, 1,2, 6,8,6,8, 0,0));
        tbl.push_back(mk(1,0,15,5,0,1, 0,0, 6,8,5,8, 0,0));
        tbl.push_back(mk(1,0,15,5,0,0, 1,0, 6,8,5,8, 0,0));
        tbl.push_back(mk(1,0,15,5,0,1, 1,0, 5,8,5,8, 0,0));
        tbl.push_back(mk(1,0,15,5,0,1, 0,0, 4,8,5,8, 0,0));
        tbl.push_back(mk(1,0,15,5,0,0, 1,2, 4,8,5,8, 0,0));
        tbl.push_back(mk(1,0,15,1,0,0, 0,0, 4,8,5,8, 0,0));
        tbl.push_back(mk(1,0,15,1,0,0, 1,0, 4,8,5,8, 0,0));
        tbl.push_back(mk(1,0,15,1,4,0, 1,0, 4,8,6,8, 0,0));
        tbl.push_back(mk(1,0,15,1,1,1, 1,0, 4,8,6,8, 0,0));
        tbl.push_back(mk(1,0,15,1,0,1, 0,0, 3,8,6,8, 0,0));
        tbl.push_back(mk(1,0,15,1,0,1, 1,0, 3,8,6,8, 0,1));
        tbl.push_back(mk(1,0,15,1,0,0, 1,0, 3,8,6,8, 0,1));
        tbl.push_back(mk(1,1,15,1,0,1, 0,0, 2,8,6,8, 0,1));
        tbl.push_back(mk(1,0,15,5,0,0, 0,0, 8,8,8,8, 0,0));
        tbl.push_back(mk(1,0,15,5,0,0, 1,2, 8,8,8,8, 0,0));
        tbl.push_back(mk(1,0,15,5,0,1, 1,2, 8,8,7,8, 0,0));
        tbl.push_back(mk(1,0,11,5,0,0, 0,0, 8,8,7,8, 0,0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // single-credit stack: drains, idles, re-granted after a return
        bus.credit_init[1]  = 8'd1;
        bus.stack_weight[1] = 4'd0;
        apply(mk(1,1,15,2,0,0, 0,0, 8,8,7,8, 0,0), "cr1_reinit");
        apply(mk(1,0,15,2,0,0, 0,0, 8,1,8,8, 0,0), "cr1_init");
        apply(mk(1,0,15,2,0,0, 1,1, 8,1,8,8, 0,0), "cr1_grant");
        apply(mk(1,0,15,2,0,1, 0,0, 8,0,8,8, 0,0), "cr1_drain");
        apply(mk(1,0,15,2,0,0, 0,0, 8,0,8,8, 0,0), "cr1_idle_a");
        apply(mk(1,0,15,2,0,0, 0,0, 8,0,8,8, 0,0), "cr1_idle_b");
        apply(mk(1,0,15,2,2,0, 0,0, 8,1,8,8, 0,0), "cr1_ret");
        apply(mk(1,0,15,2,0,0, 1,1, 8,1,8,8, 0,0), "cr1_regrant");
        apply(mk(1,0,15,2,0,1, 0,0, 8,0,8,8, 0,0), "cr1_drain2");

        // saturation and same-cycle return+consume on stack 3, weight 0
        bus.credit_init[3]  = 8'd255;
        bus.stack_weight[3] = 4'd0;
        apply(mk(1,1,15,0,0,0, 0,0, 8,0,8,8, 0,0), "sat_reinit");
        apply(mk(1,0,15,0,8,0, 0,0, 8,1,8,255, 0,0), "sat_init");
        apply(mk(1,0,15,8,8,0, 1,3, 8,1,8,255, 0,0), "sat_hold");
        apply(mk(1,0,15,8,8,1, 0,0, 8,1,8,255, 0,0), "sat_retfire");
        apply(mk(1,0,15,8,8,0, 1,3, 8,1,8,255, 0,0), "sat_regrant");
        apply(mk(1,0,15,8,0,1, 0,0, 8,1,8,254, 0,0), "sat_fire");
        bus.credit_init[3] = 8'd5;
        apply(mk(1,1,15,0,0,0, 0,0, 8,1,8,254, 0,0), "lvl5_reinit");
        apply(mk(1,0,15,8,0,0, 0,0, 8,1,8,5, 0,0), "lvl5_init");
        apply(mk(1,0,15,8,0,0, 1,3, 8,1,8,5, 0,0), "lvl5_grant");
        apply(mk(1,0,15,8,8,1, 0,0, 8,1,8,5, 0,0), "lvl5_retfire");
        apply(mk(1,0,15,8,0,0, 1,3, 8,1,8,5, 0,0), "lvl5_regrant");

        // stack 0 hogs the stream with fire stalled; stack 1 starves
        bus.credit_init     = {8'd8, 8'd8, 8'd8, 8'd8};
        bus.stack_weight[0] = 4'd15;
        apply(mk(1,1,15,0,0,0, 0,0, 8,1,8,5, 0,0), "stv_reinit");
        apply(mk(1,0,15,0,0,0, 0,0, 8,8,8,8, 0,0), "stv_init");
        for (int k = 1; k <= 70; k++) begin
            apply(mk(1,0,15,3,0,0, 1,0, 8,8,8,8, (k >= 64) ? 2 : 0, 0),
                  $sformatf("stv_wait%0d", k));
        end
        apply(mk(1,0,15,2,0,0, 0,0, 8,8,8,8, 2,0), "stv_release");
        apply(mk(1,0,15,2,0,0, 1,1, 8,8,8,8, 0,0), "stv_grant1");

        // reset in the middle of a grant
        apply(mk(0,0,15,2,0,1, 0,0, 0,0,0,0, 0,0), "rst_mid");
        apply(mk(1,0,15,3,0,0, 0,0, 8,8,8,8, 0,0), "rst_init");
        apply(mk(1,0,15,3,0,0, 1,0, 8,8,8,8, 0,0), "rst_ptr");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
